// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - round-robin arbiter sharing one register-file read port
// Latches the winner's address in IDLE, captures mux data in GRANT, pulses ack in RESP.
module regfile_read_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 5,
   parameter int DW   = 32,
   parameter int NREG = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*AW-1:0] req_addr,
   output logic [AW-1:0]     mux_sel,
   input  logic [DW-1:0]     mux_data,
   output logic [NREQ-1:0]   ack,
   output logic [DW-1:0]     rdata,
   output logic              rd_err,
   output logic              busy
);

   localparam int IW = $clog2(NREQ);
   localparam logic [AW-1:0] NREG_A = AW'(NREG);

   typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] gnt_idx;
   logic          err;
   logic [IW-1:0] win_idx;
   logic          win_vld;
   logic [AW-1:0] win_addr;
   logic          win_bad;

   // Scan downward from the farthest offset so the nearest set bit at/after rr_ptr wins.
   always_comb begin
      int j;
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = (int'(rr_ptr) + k) % NREQ;
         if (req[j]) begin
            win_vld = 1'b1;
            win_idx = IW'(j);
         end
      end
   end

   assign win_addr = req_addr[win_idx*AW +: AW];
   assign win_bad  = (win_addr >= NREG_A);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_vld) state_nxt = GRANT;
         GRANT:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr  <= '0;
         gnt_idx <= '0;
         err     <= 1'b0;
         mux_sel <= '0;
         ack     <= '0;
         rdata   <= '0;
         rd_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  gnt_idx <= win_idx;
                  err     <= win_bad;
                  mux_sel <= win_bad ? '0 : win_addr;
               end
            end
            GRANT: begin
               rdata  <= err ? '0 : mux_data;
               rd_err <= err;
               ack    <= NREQ'(1) << gnt_idx;
            end
            RESP: begin
               ack    <= '0;
               rd_err <= 1'b0;
               rr_ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            end
            default: begin
               ack <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - self-checking bench for regfile_read_arbiter
// Transaction-level reference model: rotation pick, register image, invalid-address rule.
module tb_regfile_read_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [19:0] req_addr;
   logic [4:0]  mux_sel;
   logic [31:0] mux_data;
   logic [3:0]  ack;
   logic [31:0] rdata;
   logic        rd_err;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int m_ptr  = 0;

   logic [4:0]  o_sel;
   logic        o_busy_g;
   logic [3:0]  o_ack_g;
   logic [3:0]  o_ack;
   logic [31:0] o_rdata;
   logic        o_err;
   logic        o_busy_r;
   logic        o_busy_i;
   logic [3:0]  o_ack_i;
   logic [31:0] o_rdata_i;
   logic        o_err_i;

   always #5 clk = ~clk;

   // Read mux: R0..R3 implemented; anything else returns a poison pattern.
   assign mux_data = (mux_sel < 5'd4) ? (32'hA0A0_0000 | {27'd0, mux_sel})
                                      : (32'hBAD0_0000 | {27'd0, mux_sel});

   regfile_read_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_addr (req_addr),
      .mux_sel  (mux_sel),
      .mux_data (mux_data),
      .ack      (ack),
      .rdata    (rdata),
      .rd_err   (rd_err),
      .busy     (busy)
   );

   function automatic int pick(input logic [3:0] r, input int ptr);
      for (int k = 0; k < 4; k++) begin
         if (r[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [31:0] regval(input int a);
      return (a < 4) ? (32'hA0A0_0000 + 32'(a)) : 32'h0;
   endfunction

   function automatic int addr_of(input logic [19:0] a, input int i);
      logic [19:0] t;
      t = a >> (i * 5);
      return int'(t[4:0]);
   endfunction

   function automatic logic [3:0] onehot(input int i);
      return (i < 0) ? 4'b0000 : 4'(1 << i);
   endfunction

   function automatic logic [19:0] pack(input int a0, input int a1, input int a2, input int a3);
      return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
   endfunction

   // One full IDLE->GRANT->RESP->IDLE pass; starts and ends at a negedge in IDLE.
   task automatic txn(input logic [3:0] r, input logic [19:0] a,
                      input logic [3:0] r2, input logic [19:0] a2);
      req = r;
      req_addr = a;
      @(negedge clk);
      o_sel = mux_sel; o_busy_g = busy; o_ack_g = ack;
      req = r2;
      req_addr = a2;
      @(negedge clk);
      o_ack = ack; o_rdata = rdata; o_err = rd_err; o_busy_r = busy;
      req = 4'b0000;
      @(negedge clk);
      o_busy_i = busy; o_ack_i = ack; o_rdata_i = rdata; o_err_i = rd_err;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req = 4'b0000;
      req_addr = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_ptr = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req = 4'b0000;
      req_addr = '0;
      @(negedge clk);
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err: got %b expected 0", rd_err); end
      checks++; if (mux_sel !== 5'd0) begin errors++; $display("FAIL reset_mux_sel: got %0d expected 0", mux_sel); end
      reset = 1'b0;
      m_ptr = 0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_single();
      logic [19:0] a;
      int w;
      a = pack(0, 2, 0, 0);
      w = pick(4'b0010, m_ptr);
      txn(4'b0010, a, 4'b0010, a);
      checks++; if (o_sel !== 5'(addr_of(a, w))) begin errors++; $display("FAIL single_sel: got %0d expected %0d", o_sel, addr_of(a, w)); end
      checks++; if (o_busy_g !== 1'b1 || o_busy_r !== 1'b1) begin errors++; $display("FAIL single_busy: got %b%b expected 11", o_busy_g, o_busy_r); end
      checks++; if (o_ack_g !== 4'b0000) begin errors++; $display("FAIL single_early_ack: got %b expected 0000", o_ack_g); end
      checks++; if (o_ack !== onehot(w)) begin errors++; $display("FAIL single_ack: got %b expected %b", o_ack, onehot(w)); end
      checks++; if (o_rdata !== regval(addr_of(a, w))) begin errors++; $display("FAIL single_rdata: got %h expected %h", o_rdata, regval(addr_of(a, w))); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL single_rd_err: got %b expected 0", o_err); end
      checks++; if (o_busy_i !== 1'b0 || o_ack_i !== 4'b0000) begin errors++; $display("FAIL single_after: got busy=%b ack=%b expected 0 0000", o_busy_i, o_ack_i); end
      checks++; if (o_rdata_i !== regval(addr_of(a, w))) begin errors++; $display("FAIL single_hold: got %h expected %h", o_rdata_i, regval(addr_of(a, w))); end
      m_ptr = (w + 1) % 4;
   endtask

   task automatic test_round_robin();
      logic [19:0] a;
      logic [3:0]  r;
      int prev, w;
      do_reset();
      a = pack(3, 2, 1, 0);
      prev = -1;
      for (int n = 0; n < 8; n++) begin
         r = 4'b1111;
         if (prev >= 0) r[prev] = 1'b0;
         w = pick(r, m_ptr);
         txn(r, a, 4'b1111, a);
         checks++; if (o_ack_g !== 4'b0000 || o_busy_g !== 1'b1) begin errors++; $display("FAIL rr_grant_cycle[%0d]: got ack=%b busy=%b expected 0000 1", n, o_ack_g, o_busy_g); end
         checks++; if (o_ack !== onehot(w)) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", n, o_ack, onehot(w)); end
         checks++; if (o_rdata !== regval(addr_of(a, w))) begin errors++; $display("FAIL rr_rdata[%0d]: got %h expected %h", n, o_rdata, regval(addr_of(a, w))); end
         checks++; if (o_busy_i !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d]: got busy=%b expected 0", n, o_busy_i); end
         m_ptr = (w + 1) % 4;
         prev = w;
      end
   endtask

   task automatic test_fairness();
      logic [19:0] a;
      logic [3:0]  seq [3];
      int w;
      a = pack(1, 2, 3, 0);
      seq[0] = 4'b0100;
      seq[1] = 4'b0101;
      seq[2] = 4'b0101;
      for (int n = 0; n < 3; n++) begin
         w = pick(seq[n], m_ptr);
         txn(seq[n], a, seq[n], a);
         checks++; if (o_ack !== onehot(w)) begin errors++; $display("FAIL fair_ack[%0d]: got %b expected %b", n, o_ack, onehot(w)); end
         checks++; if (o_rdata !== regval(addr_of(a, w))) begin errors++; $display("FAIL fair_rdata[%0d]: got %h expected %h", n, o_rdata, regval(addr_of(a, w))); end
         m_ptr = (w + 1) % 4;
      end
   endtask

   task automatic test_reset_mid();
      logic [19:0] a;
      int w;
      a = pack(0, 2, 0, 1);
      req = 4'b1010;
      req_addr = a;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (ack !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got ack=%b busy=%b expected 0000 0", ack, busy); end
      checks++; if (rdata !== 32'h0 || mux_sel !== 5'd0) begin errors++; $display("FAIL rmid_data: got rdata=%h sel=%0d expected 0 0", rdata, mux_sel); end
      reset = 1'b0;
      m_ptr = 0;
      w = pick(req, m_ptr);
      @(negedge clk);
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rmid_no_ack: got %b expected 0000", ack); end
      checks++; if (mux_sel !== 5'(addr_of(a, w))) begin errors++; $display("FAIL rmid_sel: got %0d expected %0d", mux_sel, addr_of(a, w)); end
      @(negedge clk);
      checks++; if (ack !== onehot(w)) begin errors++; $display("FAIL rmid_ack: got %b expected %b", ack, onehot(w)); end
      checks++; if (rdata !== regval(addr_of(a, w))) begin errors++; $display("FAIL rmid_rdata: got %h expected %h", rdata, regval(addr_of(a, w))); end
      req = 4'b0000;
      @(negedge clk);
      m_ptr = (w + 1) % 4;
   endtask

   task automatic test_invalid();
      logic [19:0] a;
      int w;
      a = pack(1, 0, 0, 9);
      w = pick(4'b1000, m_ptr);
      txn(4'b1000, a, 4'b1000, a);
      checks++; if (o_sel !== 5'd0) begin errors++; $display("FAIL inv_sel: got %0d expected 0", o_sel); end
      checks++; if (o_ack !== onehot(w)) begin errors++; $display("FAIL inv_ack: got %b expected %b", o_ack, onehot(w)); end
      checks++; if (o_rdata !== regval(addr_of(a, w))) begin errors++; $display("FAIL inv_rdata: got %h expected %h", o_rdata, regval(addr_of(a, w))); end
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL inv_rd_err: got %b expected 1", o_err); end
      checks++; if (o_err_i !== 1'b0) begin errors++; $display("FAIL inv_err_clear: got %b expected 0", o_err_i); end
      m_ptr = (w + 1) % 4;
      w = pick(4'b0001, m_ptr);
      txn(4'b0001, a, 4'b0001, a);
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL inv_next_err: got %b expected 0", o_err); end
      checks++; if (o_rdata !== regval(addr_of(a, w))) begin errors++; $display("FAIL inv_next_rdata: got %h expected %h", o_rdata, regval(addr_of(a, w))); end
      m_ptr = (w + 1) % 4;
   endtask

   task automatic test_addr_change();
      logic [19:0] a0, a2;
      int w;
      a0 = pack(1, 0, 0, 0);
      a2 = pack(3, 0, 0, 0);
      w = pick(4'b0001, m_ptr);
      txn(4'b0001, a0, 4'b0000, a2);
      checks++; if (o_sel !== 5'(addr_of(a0, w))) begin errors++; $display("FAIL chg_sel: got %0d expected %0d", o_sel, addr_of(a0, w)); end
      checks++; if (o_ack !== onehot(w)) begin errors++; $display("FAIL chg_ack: got %b expected %b", o_ack, onehot(w)); end
      checks++; if (o_rdata !== regval(addr_of(a0, w))) begin errors++; $display("FAIL chg_rdata: got %h expected %h", o_rdata, regval(addr_of(a0, w))); end
      m_ptr = (w + 1) % 4;
   endtask

   task automatic test_random();
      logic [19:0] a, a2;
      logic [3:0]  r, r2;
      int w, ea;
      for (int n = 0; n < 40; n++) begin
         r  = 4'($urandom_range(1, 15));
         r2 = 4'($urandom_range(0, 15));
         a  = pack($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
         a2 = pack($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
         w  = pick(r, m_ptr);
         ea = addr_of(a, w);
         txn(r, a, r2, a2);
         checks++; if (o_sel !== ((ea < 4) ? 5'(ea) : 5'd0)) begin errors++; $display("FAIL rnd_sel[%0d]: got %0d expected %0d", n, o_sel, (ea < 4) ? ea : 0); end
         checks++; if (o_ack !== onehot(w)) begin errors++; $display("FAIL rnd_ack[%0d]: got %b expected %b", n, o_ack, onehot(w)); end
         checks++; if (o_rdata !== regval(ea)) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, o_rdata, regval(ea)); end
         checks++; if (o_err !== (ea >= 4)) begin errors++; $display("FAIL rnd_rd_err[%0d]: got %b expected %b", n, o_err, (ea >= 4)); end
         m_ptr = (w + 1) % 4;
      end
   endtask

   initial begin
      reset = 1'b1;
      req = 4'b0000;
      req_addr = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_reset_mid();
      test_invalid();
      test_addr_change();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
      $fatal(1);
   end

endmodule
